// File: rtl/icache_refill_ctrl.sv
// Miss handler and line refill sequencer for a direct-mapped instruction code memory.
// Optional miss counter output enabled by defining ICACHE_MISS_CNT_EN.
module icache_refill_ctrl #(
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 64,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_valid,
    input  logic [ADDR_W-1:0] fetch_address,
    output logic              fetch_stall,
    output logic              misaligned_err,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              refill_we,
    output logic [ADDR_W-1:0] refill_address,
    output logic [31:0]       refill_data,
    output logic              busy
`ifdef ICACHE_MISS_CNT_EN
    ,
    output logic [31:0]       miss_count
`endif
);

    localparam int OFF    = $clog2(LINE_WORDS * 4);
    localparam int IDX    = $clog2(NUM_LINES);
    localparam int WW     = $clog2(LINE_WORDS);
    localparam int LINE_W = ADDR_W - OFF;
    localparam int TAG_W  = ADDR_W - OFF - IDX;
    localparam logic [WW-1:0] LAST_BEAT = WW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, REQ, FILL, COMMIT} state_t;

    state_t              state_reg;
    logic [NUM_LINES-1:0] valid_reg;
    logic [TAG_W-1:0]    tag_ram [NUM_LINES];
    logic [LINE_W-1:0]   line_reg;
    logic [WW-1:0]       cnt_reg;
    logic                flush_pend_reg;

    logic [IDX-1:0]      fetch_index;
    logic [TAG_W-1:0]    fetch_tag;
    logic                misaligned;
    logic                hit;
    logic                unused_offset;

    assign fetch_index   = fetch_address[OFF+IDX-1:OFF];
    assign fetch_tag     = fetch_address[ADDR_W-1:OFF+IDX];
    assign misaligned    = |fetch_address[1:0];
    assign hit           = valid_reg[fetch_index] && (tag_ram[fetch_index] == fetch_tag);
    assign unused_offset = &{1'b0, fetch_address[OFF-1:2]};

    assign busy        = (state_reg != IDLE);
    assign fetch_stall = busy | (fetch_valid & ~hit & ~misaligned);

    // The line register holds {tag, index} of the miss for the whole refill,
    // so the CPU may wander on fetch_address while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            valid_reg      <= '0;
            cnt_reg        <= '0;
            flush_pend_reg <= 1'b0;
            line_reg       <= '0;
            mem_req        <= 1'b0;
            mem_addr       <= '0;
            refill_we      <= 1'b0;
            refill_address <= '0;
            refill_data    <= '0;
            misaligned_err <= 1'b0;
        end else begin
            refill_we      <= 1'b0;
            misaligned_err <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (flush) begin
                        valid_reg <= '0;
                    end
                    if (fetch_valid && misaligned) begin
                        misaligned_err <= 1'b1;
                    end else if (fetch_valid && !hit) begin
                        line_reg  <= fetch_address[ADDR_W-1:OFF];
                        mem_addr  <= {fetch_address[ADDR_W-1:OFF], {OFF{1'b0}}};
                        mem_req   <= 1'b1;
                        state_reg <= REQ;
                    end
                end
                REQ: begin
                    if (flush) begin
                        flush_pend_reg <= 1'b1;
                    end
                    if (mem_gnt) begin
                        mem_req   <= 1'b0;
                        state_reg <= FILL;
                    end
                end
                FILL: begin
                    if (flush) begin
                        flush_pend_reg <= 1'b1;
                    end
                    if (mem_rvalid) begin
                        refill_we      <= 1'b1;
                        refill_address <= {line_reg, cnt_reg, 2'b00};
                        refill_data    <= mem_rdata;
                        if (cnt_reg == LAST_BEAT) begin
                            cnt_reg   <= '0;
                            state_reg <= COMMIT;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    // A flush seen at any point of the refill wins over the new line.
                    if (flush_pend_reg || flush) begin
                        valid_reg <= '0;
                    end else begin
                        valid_reg[line_reg[IDX-1:0]] <= 1'b1;
                    end
                    flush_pend_reg <= 1'b0;
                    state_reg      <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && state_reg == COMMIT) begin
            tag_ram[line_reg[IDX-1:0]] <= line_reg[LINE_W-1:IDX];
        end
    end

`ifdef ICACHE_MISS_CNT_EN
    logic [31:0] miss_count_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            miss_count_reg <= '0;
        end else if (flush) begin
            miss_count_reg <= '0;
        end else if (state_reg == IDLE && fetch_valid && !misaligned && !hit
                     && miss_count_reg != 32'hFFFF_FFFF) begin
            miss_count_reg <= miss_count_reg + 32'd1;
        end
    end

    assign miss_count = miss_count_reg;
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: cold miss, gapped beats, conflict, flush, reset and misalignment.
// Miss counter checks are compiled in when ICACHE_MISS_CNT_EN is defined.
module tb_icache_refill_ctrl;

    logic        clk;
    logic        rst_n;
    logic        fetch_valid;
    logic [31:0] fetch_address;
    logic        fetch_stall;
    logic        misaligned_err;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        refill_we;
    logic [31:0] refill_address;
    logic [31:0] refill_data;
    logic        busy;
`ifdef ICACHE_MISS_CNT_EN
    logic [31:0] miss_count;
`endif

    int pass_cnt = 0;
    int fail_cnt = 0;

    icache_refill_ctrl #(.LINE_WORDS(4), .NUM_LINES(64), .ADDR_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_valid    (fetch_valid),
        .fetch_address  (fetch_address),
        .fetch_stall    (fetch_stall),
        .misaligned_err (misaligned_err),
        .flush          (flush),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .refill_we      (refill_we),
        .refill_address (refill_address),
        .refill_data    (refill_data),
        .busy           (busy)
`ifdef ICACHE_MISS_CNT_EN
        ,
        .miss_count     (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full refill of the line holding addr; data beats are dbase+0..3.
    task automatic do_refill(input logic [31:0] addr, input int gnt_wait, input bit gaps,
                             input logic [31:0] dbase, input bit flush_mid);
        logic [31:0] base;
        base          = addr & 32'hFFFF_FFF0;
        fetch_valid   = 1'b1;
        fetch_address = addr;
        #1;
        chk("miss_stall", {31'd0, fetch_stall}, 32'd1);
        tick();
        chk("req_up", {31'd0, mem_req}, 32'd1);
        chk("req_addr", mem_addr, base);
        chk("busy_req", {31'd0, busy}, 32'd1);
        fetch_address = 32'hDEAD_BEE0;
        for (int i = 0; i < gnt_wait; i++) begin
            tick();
            chk("req_hold", {31'd0, mem_req}, 32'd1);
            chk("req_addr_hold", mem_addr, base);
            chk("stall_busy", {31'd0, fetch_stall}, 32'd1);
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("req_drop", {31'd0, mem_req}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            if (gaps && i > 0) begin
                mem_rvalid = 1'b0;
                tick();
                chk("gap_no_we", {31'd0, refill_we}, 32'd0);
            end
            mem_rvalid = 1'b1;
            mem_rdata  = dbase + 32'(i);
            if (flush_mid && i == 1) flush = 1'b1;
            tick();
            flush = 1'b0;
            chk("beat_we", {31'd0, refill_we}, 32'd1);
            chk("beat_addr", refill_address, base + 32'(4 * i));
            chk("beat_data", refill_data, dbase + 32'(i));
        end
        mem_rvalid = 1'b0;
        chk("busy_commit", {31'd0, busy}, 32'd1);
        tick();
        chk("busy_done", {31'd0, busy}, 32'd0);
        chk("we_done", {31'd0, refill_we}, 32'd0);
        fetch_address = addr;
        #1;
        chk("refetch_stall", {31'd0, fetch_stall}, flush_mid ? 32'd1 : 32'd0);
        fetch_valid = 1'b0;
        $display("refill line %h gnt_wait=%0d gaps=%0d flush=%0d", base, gnt_wait, gaps, flush_mid);
    endtask

    initial begin
        rst_n         = 1'b0;
        fetch_valid   = 1'b0;
        fetch_address = 32'h0;
        flush         = 1'b0;
        mem_gnt       = 1'b0;
        mem_rvalid    = 1'b0;
        mem_rdata     = 32'h0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_we", {31'd0, refill_we}, 32'd0);
        chk("rst_mis", {31'd0, misaligned_err}, 32'd0);
        chk("rst_stall", {31'd0, fetch_stall}, 32'd0);
`ifdef ICACHE_MISS_CNT_EN
        chk("rst_miss_cnt", miss_count, 32'd0);
`endif

        // Cold miss, grant after 2 cycles, back-to-back beats
        do_refill(32'h0000_0100, 2, 1'b0, 32'hA000_0000, 1'b0);
        fetch_valid   = 1'b1;
        fetch_address = 32'h0000_0104;
        #1;
        chk("hit_0x104_stall", {31'd0, fetch_stall}, 32'd0);
        tick();
        chk("hit_0x104_noreq", {31'd0, mem_req}, 32'd0);
        chk("hit_0x104_idle", {31'd0, busy}, 32'd0);
        fetch_valid = 1'b0;
        $display("fetch 00000104 hit");

        // Gapped beats on another line
        do_refill(32'h0000_0208, 0, 1'b1, 32'hB000_0000, 1'b0);
`ifdef ICACHE_MISS_CNT_EN
        chk("miss_cnt_two", miss_count, 32'd2);
`endif

        // Conflict: 0x500 evicts 0x100 (same index)
        do_refill(32'h0000_0500, 1, 1'b0, 32'hC000_0000, 1'b0);
        fetch_valid   = 1'b1;
        fetch_address = 32'h0000_0100;
        #1;
        chk("conflict_0x100_miss", {31'd0, fetch_stall}, 32'd1);
        fetch_address = 32'h0000_050C;
        #1;
        chk("conflict_0x50c_hit", {31'd0, fetch_stall}, 32'd0);
        fetch_valid = 1'b0;
        $display("conflict check 00000100 vs 00000500");

        // Flush during FILL: line must end invalid, earlier lines too
        do_refill(32'h0000_0300, 0, 1'b0, 32'hD000_0000, 1'b1);
        fetch_valid   = 1'b1;
        fetch_address = 32'h0000_0208;
        #1;
        chk("flush_0x208_miss", {31'd0, fetch_stall}, 32'd1);
        fetch_valid = 1'b0;
`ifdef ICACHE_MISS_CNT_EN
        chk("miss_cnt_flushed", miss_count, 32'd0);
`endif

        // Reset mid-FILL after two beats
        fetch_valid   = 1'b1;
        fetch_address = 32'h0000_0100;
        #1;
        chk("rstmid_miss", {31'd0, fetch_stall}, 32'd1);
        tick();
        fetch_valid = 1'b0;
        mem_gnt     = 1'b1;
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hE000_0000;
        tick();
        chk("rstmid_beat0", {31'd0, refill_we}, 32'd1);
        mem_rdata = 32'hE000_0001;
        tick();
        chk("rstmid_beat1", refill_address, 32'h0000_0104);
        mem_rvalid = 1'b0;
        rst_n      = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_req", {31'd0, mem_req}, 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hE000_0002;
        tick();
        chk("rstmid_ignore0", {31'd0, refill_we}, 32'd0);
        mem_rdata = 32'hE000_0003;
        tick();
        chk("rstmid_ignore1", {31'd0, refill_we}, 32'd0);
        chk("rstmid_still_idle", {31'd0, busy}, 32'd0);
        mem_rvalid    = 1'b0;
        fetch_valid   = 1'b1;
        fetch_address = 32'h0000_0100;
        #1;
        chk("rstmid_refetch_miss", {31'd0, fetch_stall}, 32'd1);
        fetch_valid = 1'b0;
        $display("reset mid-fill abandoned line 00000100");

        // Misaligned fetch
        fetch_valid   = 1'b1;
        fetch_address = 32'h0000_0102;
        #1;
        chk("mis_stall", {31'd0, fetch_stall}, 32'd0);
        tick();
        chk("mis_err", {31'd0, misaligned_err}, 32'd1);
        chk("mis_noreq", {31'd0, mem_req}, 32'd0);
        chk("mis_idle", {31'd0, busy}, 32'd0);
        fetch_valid = 1'b0;
        tick();
        chk("mis_pulse_end", {31'd0, misaligned_err}, 32'd0);
        $display("fetch 00000102 misaligned");

        $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
        $finish;
    end

endmodule
